// File: rtl/tartaruga_pkg.sv
// Shared fetch-path types: 32-bit bus and instruction words, fetch-queue entry layout.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;
  typedef logic [31:0] instruction_t;

  typedef struct packed {
    bus32_t       pc;
    instruction_t instr;
    logic         filled;
  } fetch_entry_t;

  localparam bus32_t FETCH_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic bus32_t fetch_align(input bus32_t addr);
    return addr & FETCH_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_buf_queue.sv
// In-order fetch queue: entries are allocated at grant, filled on response, popped by decode.
module fetch_buf_queue
  import tartaruga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clear_i,
  input  logic         alloc_i,
  input  bus32_t       alloc_pc_i,
  input  logic         fill_i,
  input  instruction_t fill_instr_i,
  input  logic         pop_i,
  output fetch_entry_t head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] alloc_ptr_q;
  logic [PTR_W-1:0] fill_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  // Pop, alloc and fill never target the same slot: the head is filled,
  // the fill slot is allocated-but-empty, the alloc slot is free.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (pop_i) begin
        mem_q[rd_ptr_q] <= '0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (alloc_i) begin
        mem_q[alloc_ptr_q].pc <= alloc_pc_i;
        alloc_ptr_q           <= alloc_ptr_q + 1'b1;
      end
      if (fill_i) begin
        mem_q[fill_ptr_q].instr  <= fill_instr_i;
        mem_q[fill_ptr_q].filled <= 1'b1;
        fill_ptr_q               <= fill_ptr_q + 1'b1;
      end
    end
  end

  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_buf.sv
// Decoupled instruction-fetch stage: PC, issue rule, outstanding/drop accounting around the fetch queue.
module fetch_buf
  import tartaruga_pkg::*;
#(
  parameter bus32_t      RESET_PC        = 32'h8000_0000,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         redirect_i,
  input  bus32_t       redirect_pc_i,
  output logic         imem_req_o,
  output bus32_t       imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  instruction_t imem_rdata_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output bus32_t       out_pc_o,
  output instruction_t out_instr_o
);

  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OCNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [OCNT_W-1:0] MAXO_C  = OCNT_W'(MAX_OUTSTANDING);

  bus32_t            pc_q;
  logic [CNT_W-1:0]  alloc_cnt_q;
  logic [OCNT_W-1:0] out_cnt_q;
  logic [OCNT_W-1:0] drop_cnt_q;
  fetch_entry_t      head;
  logic              grant;
  logic              fill;
  logic              pop;
  logic              dropping;

  // Request is gated by reset so the port is quiet while rstn_i is low.
  always_comb begin
    imem_req_o  = rstn_i & ~redirect_i & (alloc_cnt_q < DEPTH_C) & (out_cnt_q < MAXO_C);
    imem_addr_o = pc_q;
    grant       = imem_req_o & imem_gnt_i;
    dropping    = (drop_cnt_q != '0);
    fill        = imem_rvalid_i & ~redirect_i & ~dropping;
    out_valid_o = head.filled & ~redirect_i;
    pop         = out_valid_o & out_ready_i;
    out_pc_o    = head.pc;
    out_instr_o = head.instr;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= fetch_align(redirect_pc_i);
    end else if (grant) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      alloc_cnt_q <= '0;
    end else if (redirect_i) begin
      alloc_cnt_q <= '0;
    end else begin
      case ({grant, pop})
        2'b10:   alloc_cnt_q <= alloc_cnt_q + 1'b1;
        2'b01:   alloc_cnt_q <= alloc_cnt_q - 1'b1;
        default: alloc_cnt_q <= alloc_cnt_q;
      endcase
    end
  end

  // Every response retires one outstanding request, whether it is kept or dropped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_cnt_q <= '0;
    end else begin
      case ({grant, imem_rvalid_i})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  // On a flush everything still in flight becomes stale, minus a response landing right now.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt_q <= '0;
    end else if (redirect_i) begin
      drop_cnt_q <= out_cnt_q - OCNT_W'(imem_rvalid_i);
    end else if (dropping && imem_rvalid_i) begin
      drop_cnt_q <= drop_cnt_q - 1'b1;
    end
  end

  fetch_buf_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clear_i      (redirect_i),
    .alloc_i      (grant),
    .alloc_pc_i   (pc_q),
    .fill_i       (fill),
    .fill_instr_i (imem_rdata_i),
    .pop_i        (pop),
    .head_o       (head)
  );

  a_rvalid_legal : assert property (@(posedge clk_i) disable iff (!rstn_i)
    imem_rvalid_i |-> (out_cnt_q != '0));

  a_cnt_order : assert property (@(posedge clk_i) disable iff (!rstn_i)
    (drop_cnt_q <= out_cnt_q) && (out_cnt_q <= MAXO_C));

endmodule

// File: doc/fetch_buf.md
# fetch_buf

Parametrised, decoupled instruction-fetch stage with a request/grant instruction-memory port and an in-order fetch queue. It keeps several fetches in flight, buffers returned instructions with their PCs, and hands them to decode over a valid/ready handshake. It sits between the instruction memory and decode. Back-pressure from decode comes through `out_ready_i`, and branch/jump redirects from execute come through `redirect_i`.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000: PC fetched first after reset.
- `QUEUE_DEPTH`, 4: fetch-queue entries; power of two, ≥ 2.
- `MAX_OUTSTANDING`, 2: granted-but-unanswered memory requests allowed, including ones being dropped; 1..QUEUE_DEPTH.

Ports:
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `redirect_i`  in  1  flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i`  in  32 (`bus32_t`)  redirect target.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  32  fetch address, word aligned.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response valid; responses return in order.
- `imem_rdata_i`  in  32  response instruction.
- `out_valid_o`  out  1  instruction available to decode.
- `out_ready_i`  in  1  decode accepts.
- `out_pc_o`  out  32  PC of the offered instruction.
- `out_instr_o`  out  `instruction_t`  offered instruction.

## Operation
- **Fetch PC register `pc_q`.**
  - Reset value is `RESET_PC`.
  - Increments by 4 on each `imem_req_o && imem_gnt_i`.
  - On `redirect_i`, loads `{redirect_pc_i[31:2], 2'b00}`.
- **Issue rule.**
  - `imem_req_o = ~redirect_i && (alloc_cnt < QUEUE_DEPTH) && (out_cnt < MAX_OUTSTANDING)`.
  - `imem_addr_o = pc_q`.
  - Request and address stay stable until granted, unless a redirect occurs.
- **Queue** (three pointers, each `log2(QUEUE_DEPTH)` bits, wrap modulo depth).
  - A grant allocates the entry at `alloc_ptr` and writes its PC.
  - A non-dropped response fills the entry at `fill_ptr` with `imem_rdata_i` and sets its `filled` bit.
  - `out_valid_o = filled[rd_ptr] && ~redirect_i`.
  - A pop (`out_valid_o && out_ready_i`) clears the head entry and advances `rd_ptr`.
  - `alloc_cnt` counts allocated entries, filled or not. Grant and pop in the same cycle leave it unchanged.
- **Outstanding counter `out_cnt`.** Increments on grant and decrements on any response. Both in one cycle means no change.
- **Redirect (flush).**
  - Clears every `filled` bit.
  - Resets all three pointers and `alloc_cnt` to 0.
  - `drop_cnt <= out_cnt - imem_rvalid_i`: every request still in flight is marked for discard.
  - A response arriving in the redirect cycle is discarded.
- **Drop.** While `drop_cnt > 0`, each `imem_rvalid_i` decrements `drop_cnt`, decrements `out_cnt`, and writes nothing to the queue.
- **Invariant:** `drop_cnt ≤ out_cnt ≤ MAX_OUTSTANDING`. A response with `out_cnt == 0` is illegal; guard it with an assertion.

## Timing
- **Reset values:**
  - `imem_req_o` = 0 while `rstn_i` is low.
  - `out_valid_o` = 0.
  - `pc_q` = `RESET_PC`.
  - All counters and pointers = 0.
  - `out_pc_o` and `out_instr_o` = 0.
- **First request:** `imem_req_o` = 1 in the first cycle after reset release, with `imem_addr_o = RESET_PC`.
- **Response timing:** earliest `imem_rvalid_i` is one cycle after the grant.
- **Output latency:** `out_valid_o` rises the cycle after the fill (the filled bit is registered). Minimum grant-to-`out_valid_o` is 2 cycles.
- **Steady-state throughput:** 1 instruction/cycle when the memory returns every cycle, `MAX_OUTSTANDING ≥ 2`, and decode is ready.
- **Queue full** (`alloc_cnt == QUEUE_DEPTH`): requests stop; they resume the cycle after a pop.
- **Redirect timing:**
  - Redirect in cycle t: no request and no handshake in cycle t.
  - First request to the new PC is in t+1. It is subject to `out_cnt < MAX_OUTSTANDING`, so the fetch can stall while drops drain.
- **Simultaneous events:** redirect beats pop, grant and fill. `out_ready_i` is ignored in a redirect cycle.
- **Reset mid-operation:** everything returns to reset values immediately. Responses to pre-reset requests are the memory's responsibility and must not arrive after reset.

## Structure
- Add to `tartaruga_pkg`:
  - `fetch_entry_t` (`pc` : `bus32_t`, `instr` : `instruction_t`, `filled` : logic).
  - `FETCH_ALIGN_MASK`.
- Sub-module `fetch_buf_queue`: the pointer/array storage with alloc, fill and pop ports plus a clear input. `fetch_buf` holds the PC, counters, drop logic and issue rule.
- `dummy_imem` needs a gnt/rvalid wrapper for testing.

## Test plan
- **Reset, always-grant memory with 1-cycle response, decode ready:** addresses are 0x80000000, 0x80000004, …; `out_pc_o` follows the same sequence; one instruction per cycle after a 2-cycle fill.
- **`out_ready_i` = 0 for 10 cycles, `QUEUE_DEPTH` = 4:**
  - Exactly 4 grants, then `imem_req_o` = 0.
  - After ready rises, instructions 0x80000000..0x8000000C pop in order, then fetch resumes at 0x80000010.
- **Redirect to 0x80000102 with 2 requests in flight:**
  - Next request address is 0x80000100.
  - The two old responses are discarded.
  - The first `out_pc_o` is 0x80000100.
- **Redirect in the same cycle as a response and a ready pop:** no handshake occurs, the response is dropped, and `drop_cnt` equals the remaining in-flight count.
- **Grant withheld 3 cycles:** `imem_addr_o` stays stable, `pc_q` does not advance, and no duplicate queue entry appears.
- **Reset asserted while 2 requests are outstanding and the queue holds 3 entries:** outputs return to reset values immediately, and the first post-reset request is to `RESET_PC`.
